// File: rtl/jpeg_enc_defs.sv
// Shared encoder constants: colour codes, block size, reader states, conversion coefficients
// and the fixed-point helpers used by the RGB-to-YCbCr front end.
package jpeg_enc_defs;

    localparam int         BLOCK_SIZE = 64;
    localparam logic [5:0] LAST_ADDR  = 6'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {
        COLOR_Y  = 2'd0,
        COLOR_CB = 2'd1,
        COLOR_CR = 2'd2
    } color_e;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_SEND = 1'b1
    } rd_state_e;

    // Coefficients scaled by 256; every product of an 8-bit pixel fits in signed 18 bits.
    localparam logic signed [17:0] C_Y_R  =  18'sd77;
    localparam logic signed [17:0] C_Y_G  =  18'sd150;
    localparam logic signed [17:0] C_Y_B  =  18'sd29;
    localparam logic signed [17:0] C_CB_R = -18'sd43;
    localparam logic signed [17:0] C_CB_G = -18'sd85;
    localparam logic signed [17:0] C_CB_B =  18'sd128;
    localparam logic signed [17:0] C_CR_R =  18'sd128;
    localparam logic signed [17:0] C_CR_G = -18'sd107;
    localparam logic signed [17:0] C_CR_B = -18'sd21;

    typedef struct packed {
        logic             valid;
        logic             bank;
        logic [5:0]       addr;
        logic [8:0][17:0] prod;
    } s1_t;

    typedef struct packed {
        logic        valid;
        logic        bank;
        logic [5:0]  addr;
        logic [26:0] ycc;
    } s2_t;

    function automatic logic [17:0] mul_px(input logic [7:0] px, input logic signed [17:0] coef);
        logic signed [17:0] px_s;
        px_s = {10'd0, px};
        return px_s * coef;
    endfunction

    function automatic logic [8:0] sum_round_clamp(input logic [17:0] p0, input logic [17:0] p1,
                                                   input logic [17:0] p2,
                                                   input logic signed [19:0] offset);
        logic signed [19:0] acc;
        acc = 20'($signed(p0)) + 20'($signed(p1)) + 20'($signed(p2)) + 20'sd128;
        acc = (acc >>> 8) + offset;
        if (acc > 20'sd127) begin
            return 9'h07F;
        end else if (acc < -20'sd128) begin
            return 9'h180;
        end
        return acc[8:0];
    endfunction

    // Stored word layout is {Y, Cb, Cr}, 9 bits each.
    function automatic logic [8:0] pick_color(input logic [26:0] ycc, input logic [1:0] color);
        case (color)
            COLOR_Y:  return ycc[26:18];
            COLOR_CB: return ycc[17:9];
            default:  return ycc[8:0];
        endcase
    endfunction

endpackage

// File: rtl/jpeg_rgb2ycbcr_mem.sv
// One 64 x 27-bit block bank holding {Y, Cb, Cr} per pixel.
// Synchronous write, combinational read.
module jpeg_rgb2ycbcr_mem
    import jpeg_enc_defs::*;
(
    input  logic        clk,
    input  logic        we,
    input  logic [5:0]  waddr,
    input  logic [26:0] wdata,
    input  logic [5:0]  raddr,
    output logic [26:0] rdata
);

    logic [26:0] mem_q [BLOCK_SIZE];

    // NOTE: the storage array has no reset; validity is tracked by the Full flags, so clearing
    // those discards buffered data without touching every word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/jpeg_rgb2ycbcr.sv
// RGB pixel stream to level-shifted YCbCr 4:4:4 blocks: 2-stage conversion pipeline into a
// ping-pong pair of block buffers, replayed as Y, Cb, Cr components of 64 samples each.
module jpeg_rgb2ycbcr
    import jpeg_enc_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        InEnable,
    output logic        InReady,
    input  logic [7:0]  InR,
    input  logic [7:0]  InG,
    input  logic [7:0]  InB,
    input  logic [11:0] InBlockWidth,
    output logic        OutEnable,
    input  logic        OutReady,
    output logic [1:0]  OutColor,
    output logic [5:0]  OutAddress,
    output logic [8:0]  OutData,
    output logic [11:0] OutBlockX,
    output logic [11:0] OutBlockY
);

    logic             wr_bank_q, wr_bank_d;
    logic [5:0]       wr_addr_q, wr_addr_d;
    logic [11:0]      blk_x_q, blk_x_d;
    logic [11:0]      blk_y_q, blk_y_d;
    logic [1:0][11:0] tag_x_q, tag_x_d;
    logic [1:0][11:0] tag_y_q, tag_y_d;
    s1_t              s1_q, s1_d;
    s2_t              s2_q, s2_d;
    logic [1:0]       full_q, full_d;
    rd_state_e        state_q, state_d;
    logic             rd_bank_q, rd_bank_d;
    logic             out_en_q, out_en_d;
    logic [1:0]       out_color_q, out_color_d;
    logic [5:0]       out_addr_q, out_addr_d;
    logic [8:0]       out_data_q, out_data_d;
    logic [11:0]      out_bx_q, out_bx_d;
    logic [11:0]      out_by_q, out_by_d;

    logic        in_accept;
    logic [5:0]  rd_addr;
    logic [1:0]  rd_color;
    logic [26:0] rdata0, rdata1, rd_word;
    logic [5:0]  nxt_addr;
    logic [1:0]  nxt_color;

    assign InReady   = !full_q[wr_bank_q];
    assign in_accept = InEnable && InReady;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_addr_d = wr_addr_q;
        blk_x_d   = blk_x_q;
        blk_y_d   = blk_y_q;
        tag_x_d   = tag_x_q;
        tag_y_d   = tag_y_q;
        if (in_accept) begin
            wr_addr_d = wr_addr_q + 6'd1;
            if (wr_addr_q == LAST_ADDR) begin
                wr_bank_d          = ~wr_bank_q;
                tag_x_d[wr_bank_q] = blk_x_q;
                tag_y_d[wr_bank_q] = blk_y_q;
                if (blk_x_q + 12'd1 == InBlockWidth) begin
                    blk_x_d = '0;
                    blk_y_d = blk_y_q + 12'd1;
                end else begin
                    blk_x_d = blk_x_q + 12'd1;
                end
            end
        end
    end

    always_comb begin
        s1_d.valid   = in_accept;
        s1_d.bank    = wr_bank_q;
        s1_d.addr    = wr_addr_q;
        s1_d.prod[0] = mul_px(InR, C_Y_R);
        s1_d.prod[1] = mul_px(InG, C_Y_G);
        s1_d.prod[2] = mul_px(InB, C_Y_B);
        s1_d.prod[3] = mul_px(InR, C_CB_R);
        s1_d.prod[4] = mul_px(InG, C_CB_G);
        s1_d.prod[5] = mul_px(InB, C_CB_B);
        s1_d.prod[6] = mul_px(InR, C_CR_R);
        s1_d.prod[7] = mul_px(InG, C_CR_G);
        s1_d.prod[8] = mul_px(InB, C_CR_B);

        s2_d.valid = s1_q.valid;
        s2_d.bank  = s1_q.bank;
        s2_d.addr  = s1_q.addr;
        s2_d.ycc   = {sum_round_clamp(s1_q.prod[0], s1_q.prod[1], s1_q.prod[2], -20'sd128),
                      sum_round_clamp(s1_q.prod[3], s1_q.prod[4], s1_q.prod[5], 20'sd0),
                      sum_round_clamp(s1_q.prod[6], s1_q.prod[7], s1_q.prod[8], 20'sd0)};
    end

    jpeg_rgb2ycbcr_mem u_bank0 (
        .clk   (clk),
        .we    (s2_q.valid && !s2_q.bank),
        .waddr (s2_q.addr),
        .wdata (s2_q.ycc),
        .raddr (rd_addr),
        .rdata (rdata0)
    );

    jpeg_rgb2ycbcr_mem u_bank1 (
        .clk   (clk),
        .we    (s2_q.valid && s2_q.bank),
        .waddr (s2_q.addr),
        .wdata (s2_q.ycc),
        .raddr (rd_addr),
        .rdata (rdata1)
    );

    assign rd_word   = rd_bank_q ? rdata1 : rdata0;
    assign nxt_addr  = out_addr_q + 6'd1;
    assign nxt_color = (out_addr_q == LAST_ADDR) ? out_color_q + 2'd1 : out_color_q;

    // The output registers double as the reader's colour/address counters.
    always_comb begin
        state_d     = state_q;
        rd_bank_d   = rd_bank_q;
        full_d      = full_q;
        out_en_d    = out_en_q;
        out_color_d = out_color_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_bx_d    = out_bx_q;
        out_by_d    = out_by_q;
        rd_addr     = '0;
        rd_color    = COLOR_Y;

        if (s2_q.valid && s2_q.addr == LAST_ADDR) begin
            full_d[s2_q.bank] = 1'b1;
        end

        case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d     = RD_SEND;
                    out_en_d    = 1'b1;
                    out_color_d = COLOR_Y;
                    out_addr_d  = '0;
                    out_data_d  = pick_color(rd_word, rd_color);
                    out_bx_d    = tag_x_q[rd_bank_q];
                    out_by_d    = tag_y_q[rd_bank_q];
                end
            end
            default: begin
                if (OutReady) begin
                    if (out_color_q == COLOR_CR && out_addr_q == LAST_ADDR) begin
                        state_d           = RD_IDLE;
                        out_en_d          = 1'b0;
                        full_d[rd_bank_q] = 1'b0;
                        rd_bank_d         = ~rd_bank_q;
                    end else begin
                        rd_addr     = nxt_addr;
                        rd_color    = nxt_color;
                        out_addr_d  = nxt_addr;
                        out_color_d = nxt_color;
                        out_data_d  = pick_color(rd_word, rd_color);
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q   <= 1'b0;
            wr_addr_q   <= '0;
            blk_x_q     <= '0;
            blk_y_q     <= '0;
            tag_x_q     <= '0;
            tag_y_q     <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            full_q      <= '0;
            state_q     <= RD_IDLE;
            rd_bank_q   <= 1'b0;
            out_en_q    <= 1'b0;
            out_color_q <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_bx_q    <= '0;
            out_by_q    <= '0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_addr_q   <= wr_addr_d;
            blk_x_q     <= blk_x_d;
            blk_y_q     <= blk_y_d;
            tag_x_q     <= tag_x_d;
            tag_y_q     <= tag_y_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            full_q      <= full_d;
            state_q     <= state_d;
            rd_bank_q   <= rd_bank_d;
            out_en_q    <= out_en_d;
            out_color_q <= out_color_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_bx_q    <= out_bx_d;
            out_by_q    <= out_by_d;
        end
    end

    assign OutEnable  = out_en_q;
    assign OutColor   = out_color_q;
    assign OutAddress = out_addr_q;
    assign OutData    = out_data_q;
    assign OutBlockX  = out_bx_q;
    assign OutBlockY  = out_by_q;

endmodule

// File: tb/tb_jpeg_rgb2ycbcr.sv
// Directed bench for jpeg_rgb2ycbcr: a source queue feeds pixels, completed input blocks push
// their 192 expected samples to a scoreboard that is popped on every output transfer.
`timescale 1ns/1ps
module tb_jpeg_rgb2ycbcr;

    logic        clk = 1'b0;
    logic        rst;
    logic        InEnable;
    logic        InReady;
    logic [7:0]  InR, InG, InB;
    logic [11:0] InBlockWidth;
    logic        OutEnable;
    logic        OutReady;
    logic [1:0]  OutColor;
    logic [5:0]  OutAddress;
    logic [8:0]  OutData;
    logic [11:0] OutBlockX, OutBlockY;

    always #5 clk = ~clk;

    jpeg_rgb2ycbcr dut (
        .clk          (clk),
        .rst          (rst),
        .InEnable     (InEnable),
        .InReady      (InReady),
        .InR          (InR),
        .InG          (InG),
        .InB          (InB),
        .InBlockWidth (InBlockWidth),
        .OutEnable    (OutEnable),
        .OutReady     (OutReady),
        .OutColor     (OutColor),
        .OutAddress   (OutAddress),
        .OutData      (OutData),
        .OutBlockX    (OutBlockX),
        .OutBlockY    (OutBlockY)
    );

    typedef logic [40:0] smp_t;  // {color, addr, data, block x, block y}

    int          n_assert = 0;
    int          n_fail   = 0;
    smp_t        exp_q[$];
    logic [23:0] src_q[$];
    logic [26:0] blk_buf [64];
    int          tb_addr, tb_bx, tb_by, tb_width;
    int          cyc, last63_cyc, first_oe_cyc, n_acc, ready_mode;
    bit          oe_armed, held_valid;
    smp_t        held;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [8:0] clamp9(input int v);
        int c;
        c = (v > 127) ? 127 : ((v < -128) ? -128 : v);
        return 9'(c);
    endfunction

    function automatic logic [26:0] ref_ycc(input int r, input int g, input int b);
        int y, cb, cr;
        y  = ((77 * r + 150 * g + 29 * b + 128) >>> 8) - 128;
        cb = (-43 * r - 85 * g + 128 * b + 128) >>> 8;
        cr = (128 * r - 107 * g - 21 * b + 128) >>> 8;
        return {clamp9(y), clamp9(cb), clamp9(cr)};
    endfunction

    task automatic model_accept(input logic [23:0] px);
        logic [8:0] d;
        blk_buf[tb_addr] = ref_ycc(int'(px[23:16]), int'(px[15:8]), int'(px[7:0]));
        if (tb_addr == 63) begin
            last63_cyc = cyc;
            for (int c = 0; c < 3; c++) begin
                for (int a = 0; a < 64; a++) begin
                    d = (c == 0) ? blk_buf[a][26:18] : ((c == 1) ? blk_buf[a][17:9] : blk_buf[a][8:0]);
                    exp_q.push_back({2'(c), 6'(a), d, 12'(tb_bx), 12'(tb_by)});
                end
            end
            if (tb_bx + 1 == tb_width) begin
                tb_bx = 0;
                tb_by = (tb_by + 1) % 4096;
            end else begin
                tb_bx = tb_bx + 1;
            end
            tb_addr = 0;
        end else begin
            tb_addr++;
        end
    endtask

    // One clock: drive at the falling edge, observe the registered outputs, predict the
    // handshakes that the following rising edge will perform.
    task automatic cycle();
        smp_t obs;
        smp_t e;
        @(negedge clk);
        cyc++;
        case (ready_mode)
            0:       OutReady = 1'b1;
            1:       OutReady = 1'b0;
            default: OutReady = 1'($urandom_range(0, 1));
        endcase
        if (src_q.size() > 0) begin
            InEnable = 1'b1;
            {InR, InG, InB} = src_q[0];
        end else begin
            InEnable = 1'b0;
        end
        obs = {OutColor, OutAddress, OutData, OutBlockX, OutBlockY};
        if (held_valid) chk("stall_hold", 64'({OutEnable, obs}), 64'({1'b1, held}));
        if (OutEnable && oe_armed) begin
            first_oe_cyc = cyc;
            oe_armed     = 1'b0;
        end
        if (OutEnable && OutReady) begin
            n_assert++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_sample: observed %0h expected no sample", obs);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sample", 64'(obs), 64'(e));
            end
        end
        held_valid = OutEnable && !OutReady;
        held       = obs;
        if (InEnable && InReady) begin
            n_acc++;
            model_accept(src_q.pop_front());
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0 || OutEnable) && n < budget) begin
            cycle();
            n++;
        end
        chk({tag, "_drained"}, 64'(src_q.size() + exp_q.size()), 64'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst      = 1'b1;
        InEnable = 1'b0;
        src_q.delete();
        exp_q.delete();
        tb_addr    = 0;
        tb_bx      = 0;
        tb_by      = 0;
        held_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(InReady), 64'd1);
        chk("rst_out_enable", 64'(OutEnable), 64'd0);
        chk("rst_out_fields", 64'({OutColor, OutAddress, OutData, OutBlockX, OutBlockY}), 64'd0);
        rst = 1'b0;
    endtask

    task automatic push_block(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        for (int i = 0; i < 64; i++) src_q.push_back({r, g, b});
    endtask

    task automatic push_gradient();
        logic [7:0] a4;
        for (int i = 0; i < 64; i++) begin
            a4 = 8'(i * 4);
            src_q.push_back({a4, 8'(255 - i * 4), 8'd128});
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; InEnable = 1'b0; InR = '0; InG = '0; InB = '0; OutReady = 1'b1;
        InBlockWidth = 12'd1; tb_width = 1; ready_mode = 0; cyc = 0; n_acc = 0;
        oe_armed = 1'b0; held_valid = 1'b0; last63_cyc = 0; first_oe_cyc = 0;
        apply_reset();

        // White block at (0,0); OutEnable observed 4 falling edges after the pixel-63
        // falling edge, i.e. right after the third rising edge following acceptance.
        oe_armed = 1'b1;
        push_block(8'd255, 8'd255, 8'd255);
        drain("white", 1000);
        chk("first_oe_latency", 64'(first_oe_cyc - last63_cyc), 64'd4);

        // Saturating colours: red clamps Cr, blue clamps Cb.
        push_block(8'd255, 8'd0, 8'd0);
        push_block(8'd0, 8'd0, 8'd255);
        drain("red_blue", 2000);

        // Two blocks per row: coordinates (0,0) (1,0) (0,1) (1,1).
        InBlockWidth = 12'd2;
        tb_width     = 2;
        apply_reset();
        for (int i = 0; i < 4; i++) push_block(8'd0, 8'd0, 8'd0);
        drain("black", 3000);

        // Sink stalled while three blocks are offered: both banks fill, input stops.
        ready_mode = 1;
        n_acc      = 0;
        push_block(8'd10, 8'd200, 8'd30);
        push_block(8'd0, 8'd255, 8'd0);
        push_block(8'd255, 8'd255, 8'd0);
        repeat (250) cycle();
        chk("stall_accepted", 64'(n_acc), 64'd128);
        chk("stall_in_ready", 64'(InReady), 64'd0);
        chk("stall_out_enable", 64'(OutEnable), 64'd1);
        ready_mode = 0;
        drain("stall", 3000);

        // Random back-pressure with a gradient pattern.
        ready_mode = 2;
        push_gradient();
        push_gradient();
        drain("random", 5000);
        ready_mode = 0;

        // Reset while one block is being replayed and another is half written.
        push_block(8'd255, 8'd255, 8'd255);
        for (int i = 0; i < 30; i++) src_q.push_back({8'd255, 8'd0, 8'd0});
        repeat (100) cycle();
        chk("pre_reset_busy", 64'(OutEnable), 64'd1);
        apply_reset();
        push_block(8'd40, 8'd90, 8'd160);
        drain("after_reset", 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/jpeg_rgb2ycbcr.md
# jpeg_rgb2ycbcr

Encoder-side colour front end. Accepts an RGB pixel stream, one 8x8 block at a time in raster order. Converts each pixel to level-shifted YCbCr (4:4:4) through a 2-stage pipeline into a ping-pong pair of block buffers. Replays each complete block as three 64-sample components (Y, Cb, Cr) toward the forward DCT. It is the mirror of the decoder's YCbCr-to-RGB stage and produces the same 9-bit signed sample format that stage consumes.

## Interface
Parameters:
- none. Block size (64) and coefficients are fixed constants.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- InEnable  in  1  pixel valid.
- InReady  out  1  pixel is accepted on a rising edge where InEnable & InReady.
- InR, InG, InB  in  8 each  unsigned pixel.
- InBlockWidth  in  12  blocks per image row. Must be ≥1 and stable while a frame is in flight.
- OutEnable  out  1  sample valid.
- OutReady  in  1  sample is consumed on a rising edge where OutEnable & OutReady.
- OutColor  out  2  0=Y, 1=Cb, 2=Cr.
- OutAddress  out  6  raster index within the block.
- OutData  out  9  signed, two's complement.
- OutBlockX, OutBlockY  out  12 each  block coordinates.

## Operation
- Conversion, integer with 8 fractional bits, rounded, arithmetic shift:
  - Y = ((77R+150G+29B+128)>>>8) − 128
  - Cb = (−43R−85G+128B+128)>>>8
  - Cr = (128R−107G−21B+128)>>>8
  - Each result is clamped to [−128,127], then sign-extended to 9 bits.
  - Products fit in signed 18 bits.
- Pipeline:
  - S1 registers the products.
  - S2 sums, rounds, shifts and clamps.
  - The write stage stores Y/Cb/Cr at the tagged bank/address.
  - Each stage carries valid, bank and address tags.
- Writer:
  - wr_bank and wr_addr advance on each accepted pixel.
  - On acceptance of address 63, wr_bank toggles and the block counters advance.
    - X wraps to 0 when X+1 == InBlockWidth, and Y increments.
    - Y wraps modulo 4096.
  - The current block X/Y is latched into that bank's tag.
- Bank flags:
  - Full[b] is set when the write of address 63 to bank b retires.
  - Full[b] is cleared by the reader.
  - InReady = !Full[wr_bank].
- Reader FSM:
  - IDLE: if Full[rd_bank], load colour 0 / address 0 → SEND.
  - SEND: on transfer, advance address 0..63, then colour 0..2.
  - On transfer of colour 2 / address 63:
    - OutEnable is 0 next cycle.
    - Full[rd_bank] is cleared on the same edge.
    - rd_bank toggles.
    - FSM → IDLE.
- Boundary conditions:
  - Set of Full on one bank and clear on the other in the same cycle: both take effect.
  - The same bank can never be set and cleared in the same cycle.
  - Both banks full: InReady = 0 and the pipeline drains normally. Nothing is ever lost or overwritten.
  - OutReady low: OutEnable, OutColor, OutAddress, OutData and OutBlockX/Y hold stable.
  - Reset mid-operation: all in-flight and buffered data is discarded.

## Timing
- Reset values:
  - InReady = 1.
  - OutEnable = 0; OutColor, OutAddress, OutData, OutBlockX, OutBlockY = 0.
  - Full flags, pipeline valids, all counters and banks = 0; FSM = IDLE.
- Latency:
  - Pixel 63 accepted at edge t: S1 at t, S2 at t+1, write and Full set at t+2.
  - OutEnable = 1 after edge t+3.
- Throughput:
  - Input: 1 pixel/cycle while a bank is free.
  - Output: 1 sample/cycle with OutReady high.
  - One idle cycle between output blocks.
- Output registers update only when !OutEnable | OutReady.
- Buffer memory: write-synchronous, combinational read. The output register provides the only read latency.

## Structure
- Shared encoder constants include/package (jpeg_enc_defs):
  - coefficient constants;
  - colour codes (Y=0, Cb=1, Cr=2);
  - block size 64;
  - reader FSM state encodings.
- Sub-module jpeg_rgb2ycbcr_mem:
  - one 64x27-bit bank (Y|Cb|Cr);
  - two instances, selected by bank tag on write and by rd_bank on read.

## Test plan
- Reset, then one block of R=G=B=255 → 192 samples. Y=127 at all addresses, then Cb=0, then Cr=0. OutBlockX/Y = 0/0. First OutEnable 3 cycles after pixel 63 is accepted.
- One block of pure red (255,0,0) → Y=−51, Cb=−43, Cr=127 (clamped from 128). One block of pure blue (0,0,255) → Cb=127 (clamped).
- InBlockWidth=2, four black blocks (0,0,0) → Y=−128, Cb=Cr=0. Block coordinates in order (0,0), (1,0), (0,1), (1,1).
- OutReady held low while the source streams 3 blocks → InReady drops after 128 pixels are accepted. No sample is lost or changed once OutReady is released.
- OutReady toggling randomly plus raster-gradient input (R=addr·4, G=255−addr·4, B=128) → output matches the reference model bit-exactly. Outputs stay stable during stalls.
- Assert rst for 1 cycle mid-block → outputs, Full and counters return to reset values. The next block is reported at (0,0).
